// File: rtl/sdram_pkg.sv
// Shared SDRAM-domain constants: scheduler state encoding, address field split,
// and the command controller's work-state encoding.
package sdram_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 8;

    // Display read-burst scheduler states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_REQ   = 3'd4;
    localparam logic [2:0] S_XFER  = 3'd5;

    // SDRAM command controller work states
    localparam logic [3:0] W_INIT      = 4'd0;
    localparam logic [3:0] W_IDLE      = 4'd1;
    localparam logic [3:0] W_REFRESH   = 4'd2;
    localparam logic [3:0] W_ACTIVATE  = 4'd3;
    localparam logic [3:0] W_READ      = 4'd4;
    localparam logic [3:0] W_WRITE     = 4'd5;
    localparam logic [3:0] W_PRECHARGE = 4'd6;

endpackage

// File: rtl/vga_rd_sched.sv
// Display-path read-burst scheduler: keeps the display FIFO topped up with
// fixed-size SDRAM read bursts walking linearly through one frame buffer.
module vga_rd_sched
    import sdram_pkg::*;
#(
    parameter int                ADDR_W      = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_WORDS = 307200,
    parameter int                BURST_LEN   = 256,
    parameter int                LOW_MARK    = 512,
    parameter int                CLR_CYCLES  = 4,
    parameter int                SETTLE      = 3
) (
    input  logic              clk_133M_i,
    input  logic              rst_133i,
    input  logic              frame_start_i,
    input  logic [10:0]       fifo_used_i,
    output logic              rd_req_o,
    input  logic              rd_ack_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [8:0]        rd_len_o,
    input  logic              rd_done_i,
    output logic              fifo_clear_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [2:0]        dbg_state_o
);

    localparam logic [19:0] FRAME_W20 = 20'(FRAME_WORDS);
    localparam logic [19:0] BURST_W20 = 20'(BURST_LEN);
    localparam logic [7:0]  CLR_LAST  = 8'(CLR_CYCLES - 1);
    localparam logic [7:0]  SET_LAST  = 8'(SETTLE - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [19:0]       remaining_q, remaining_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [8:0]        rd_len_q, rd_len_d;
    logic              rd_req_q, fifo_clear_q, busy_q, frame_done_q;
    logic              frame_done_d;
    logic              enter_clear;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_addr_d  = word_addr_q;
        remaining_d  = remaining_q;
        pend_d       = pend_q;
        rd_addr_d    = rd_addr_q;
        rd_len_d     = rd_len_q;
        frame_done_d = 1'b0;
        enter_clear  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) enter_clear = 1'b1;
            end
            S_CLEAR: begin
                if (frame_start_i) begin
                    enter_clear = 1'b1;
                end else if (cnt_q == CLR_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (frame_start_i) begin
                    enter_clear = 1'b1;
                end else if (cnt_q == SET_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (frame_start_i) begin
                    enter_clear = 1'b1;
                end else if (remaining_q == '0) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (int'(fifo_used_i) <= LOW_MARK) begin
                    rd_addr_d = word_addr_q;
                    rd_len_d  = (remaining_q < BURST_W20) ? remaining_q[8:0] : BURST_W20[8:0];
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (frame_start_i) pend_d = 1'b1;
                if (rd_ack_i) state_d = S_XFER;
            end
            S_XFER: begin
                if (frame_start_i) pend_d = 1'b1;
                if (rd_done_i) begin
                    word_addr_d = word_addr_q + ADDR_W'(rd_len_q);
                    // Saturating subtract keeps the counter from wrapping below zero.
                    remaining_d = (remaining_q >= 20'(rd_len_q)) ? remaining_q - 20'(rd_len_q) : '0;
                    if (pend_q || frame_start_i) begin
                        enter_clear = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_clear) begin
            state_d     = S_CLEAR;
            cnt_d       = '0;
            word_addr_d = BASE_ADDR;
            remaining_d = FRAME_W20;
            pend_d      = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            word_addr_q  <= BASE_ADDR;
            remaining_q  <= '0;
            pend_q       <= 1'b0;
            rd_addr_q    <= BASE_ADDR;
            rd_len_q     <= '0;
            rd_req_q     <= 1'b0;
            fifo_clear_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_addr_q  <= word_addr_d;
            remaining_q  <= remaining_d;
            pend_q       <= pend_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
            rd_req_q     <= (state_d == S_REQ);
            fifo_clear_q <= (state_d == S_CLEAR);
            busy_q       <= (state_d == S_REQ) || (state_d == S_XFER);
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_len_o     = rd_len_q;
    assign fifo_clear_o = fifo_clear_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vga_rd_sched.sv
// Bench for vga_rd_sched with a 1300-word frame: five full bursts plus a 20-word tail.
module tb_vga_rd_sched;
    import sdram_pkg::*;

    localparam int ADDR_W      = 22;
    localparam int FRAME_WORDS = 1300;
    localparam int BURST_LEN   = 256;
    localparam int LOW_MARK    = 512;
    localparam int CLR_CYCLES  = 4;
    localparam int SETTLE      = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [10:0]       fifo_used = '0;
    logic              rd_ack = 1'b0;
    logic              rd_done = 1'b0;
    logic              rd_req_o, fifo_clear_o, busy_o, frame_done_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [8:0]        rd_len_o;
    logic [2:0]        dbg_state_o;

    vga_rd_sched #(
        .ADDR_W(ADDR_W), .BASE_ADDR('0), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN),
        .LOW_MARK(LOW_MARK), .CLR_CYCLES(CLR_CYCLES), .SETTLE(SETTLE)
    ) dut (
        .clk_133M_i(clk), .rst_133i(rst), .frame_start_i(frame_start), .fifo_used_i(fifo_used),
        .rd_req_o(rd_req_o), .rd_ack_i(rd_ack), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
        .rd_done_i(rd_done), .fifo_clear_o(fifo_clear_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [30:0] exp_q[$];      // {addr[21:0], len[8:0]}
    logic [30:0] cur_exp = '0;
    int  ack_delay = 0;
    int  done_delay = 0;
    bit  resp_en = 1'b1;
    int  cyc = 0;
    int  last_done_cyc = 0;
    int  fd_cnt = 0;
    int  req_rise_cnt = 0;

    // Hand-computed burst list for one 1300-word frame.
    int exp_addr[6] = '{0, 256, 512, 768, 1024, 1280};
    int exp_len[6]  = '{256, 256, 256, 256, 256, 20};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_frame();
        for (int i = 0; i < 6; i++) exp_q.push_back({22'(exp_addr[i]), 9'(exp_len[i])});
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget);
        int n;
        n = 0;
        while (!frame_done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("frame_done_timeout", 32'(n), 32'(budget + 1));
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(rd_req_o), 0);
        chk("rst_clear", 32'(fifo_clear_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_frame_done", 32'(frame_done_o), 0);
        chk("rst_addr", 32'(rd_addr_o), 0);
        chk("rst_len", 32'(rd_len_o), 0);
        chk("rst_state", 32'(dbg_state_o), 32'(S_IDLE));
    endtask

    // SDRAM controller model: ack after ack_delay cycles, done after done_delay more.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (!rst && rd_req_o && resp_en) begin
                repeat (ack_delay) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
                repeat (done_delay) @(negedge clk);
                rd_done = 1'b1;
                @(negedge clk);
                rd_done = 1'b0;
            end
        end
    end

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
            if (rd_done) last_done_cyc = cyc;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic prev_req, prev_clr;
        int   req_w, clr_w;
        prev_req = 1'b0; prev_clr = 1'b0; req_w = 0; clr_w = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0; prev_clr = 1'b0; req_w = 0; clr_w = 0;
            end else begin
                if (rd_req_o && !prev_req) begin
                    req_rise_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req_addr", 32'(rd_addr_o), 32'hFFFF_FFFF);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        chk("req_addr", 32'(rd_addr_o), 32'(cur_exp[30:9]));
                        chk("req_len", 32'(rd_len_o), 32'(cur_exp[8:0]));
                    end
                end
                if (rd_req_o) req_w++;
                if (!rd_req_o && prev_req) begin
                    chk("req_width", 32'(req_w), 32'(ack_delay + 1));
                    chk("addr_hold", 32'(rd_addr_o), 32'(cur_exp[30:9]));
                    chk("busy_in_xfer", 32'(busy_o), 1);
                    req_w = 0;
                end
                if (fifo_clear_o) clr_w++;
                if (!fifo_clear_o && prev_clr) begin
                    chk("clear_width", 32'(clr_w), 32'(CLR_CYCLES));
                    clr_w = 0;
                end
                if (frame_done_o) begin
                    fd_cnt++;
                    chk("frame_done_latency", 32'(cyc - last_done_cyc), 32'(SETTLE + 1));
                end
                prev_req = rd_req_o;
                prev_clr = fifo_clear_o;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        int fd0, rise0, n;

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame, immediate ack/done, FIFO empty.
        fd0 = fd_cnt;
        push_frame();
        pulse_frame_start();
        chk("clear_starts", 32'(fifo_clear_o), 1);
        wait_frame_done(2000);
        chk("t1_frame_done_count", 32'(fd_cnt - fd0), 1);
        chk("t1_queue_drained", 32'(exp_q.size()), 0);

        // Low-mark gating at 700 and 513, release at 512; slow ack.
        fd0 = fd_cnt;
        rise0 = req_rise_cnt;
        fifo_used = 11'd700;
        ack_delay = 10;
        push_frame();
        pulse_frame_start();
        repeat (40) @(negedge clk);
        chk("t2_no_req_700", 32'(req_rise_cnt - rise0), 0);
        fifo_used = 11'd513;
        repeat (20) @(negedge clk);
        chk("t2_no_req_513", 32'(req_rise_cnt - rise0), 0);
        fifo_used = 11'd512;
        @(negedge clk);
        chk("t2_req_after_512", 32'(rd_req_o), 1);
        wait_frame_done(3000);
        chk("t2_frame_done_count", 32'(fd_cnt - fd0), 1);
        ack_delay = 0;
        fifo_used = '0;

        // Restart during the transfer of the burst at 1024.
        fd0 = fd_cnt;
        done_delay = 20;
        push_frame();
        exp_q.delete(5);
        push_frame();
        pulse_frame_start();
        n = 0;
        while (!(busy_o && !rd_req_o && rd_addr_o == 22'd1024) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_reach_xfer_1024", 32'(n < 1000), 1);
        pulse_frame_start();
        chk("t3_no_clear_mid_xfer", 32'(fifo_clear_o), 0);
        chk("t3_still_busy", 32'(busy_o), 1);
        n = 0;
        while (!rd_done && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("t3_clear_after_done", 32'(fifo_clear_o), 1);
        wait_frame_done(3000);
        chk("t3_frame_done_count", 32'(fd_cnt - fd0), 1);
        chk("t3_queue_drained", 32'(exp_q.size()), 0);
        done_delay = 0;

        // Reset while a request is pending.
        resp_en = 1'b0;
        exp_q.push_back({22'd0, 9'd256});
        pulse_frame_start();
        n = 0;
        while (!rd_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_req_seen", 32'(rd_req_o), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        resp_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("t4_idle_no_req", 32'(rd_req_o), 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
